// File: rtl/mux4x32_rr_arbiter.sv
// Round-robin arbiter: four requesters share one 32-bit result slot.
// Ports: Clk, Clrn (async low); Req, A0..A3, Ready in; Gnt, Y, Sel, Valid out.
module mux4x32_rr_arbiter (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [3:0]  Req,
  input  logic [31:0] A0,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [31:0] A3,
  input  logic        Ready,
  output logic [3:0]  Gnt,
  output logic [31:0] Y,
  output logic [1:0]  Sel,
  output logic        Valid
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e       state;
  logic [1:0]  ptr;
  logic        free;
  logic [3:0]  elig;
  logic [7:0]  dbl;
  logic [3:0]  rot;
  logic [1:0]  off;
  logic [1:0]  win;
  logic        any;
  logic [31:0] mux_y;

  assign Valid = (state == FULL);
  assign free  = !Valid || Ready;
  // A requester granted on the last edge sits out one cycle.
  assign elig  = Req & ~Gnt;
  assign any   = |elig;
  // Rotate so bit 0 is the requester at ptr.
  assign dbl   = {elig, elig};
  assign rot   = dbl[ptr +: 4];

  always_comb begin
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign win = ptr + off;

  // MUX4X32 driven by the combinational winner.
  always_comb begin
    mux_y = A0;
    unique case (win)
      2'd0: mux_y = A0;
      2'd1: mux_y = A1;
      2'd2: mux_y = A2;
      2'd3: mux_y = A3;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= EMPTY;
      ptr   <= 2'd0;
      Gnt   <= 4'd0;
      Y     <= 32'd0;
      Sel   <= 2'd0;
    end else begin
      Gnt <= 4'd0;
      if (free) begin
        if (any) begin
          state <= FULL;
          Y     <= mux_y;
          Sel   <= win;
          Gnt   <= 4'b0001 << win;
          ptr   <= win + 2'd1;
        end else begin
          state <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux4x32_rr_arbiter.sv
// Directed table-driven bench for mux4x32_rr_arbiter.
// Async reset, rotation, backpressure, wrap, lone requester.
module tb_mux4x32_rr_arbiter;

  logic        Clk;
  logic        Clrn;
  logic [3:0]  Req;
  logic [31:0] A0, A1, A2, A3;
  logic        Ready;
  logic [3:0]  Gnt;
  logic [31:0] Y;
  logic [1:0]  Sel;
  logic        Valid;

  int checks;
  int errors;

  localparam logic [31:0] W0 = 32'h12345678;
  localparam logic [31:0] W1 = 32'h87654321;
  localparam logic [31:0] W2 = 32'hABCDEF01;
  localparam logic [31:0] W3 = 32'h10101010;
  localparam logic [31:0] WF = 32'hFFFFFFFF;
  localparam logic [31:0] WA = 32'hAAAAAAAA;

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [31:0] a0, a1, a2, a3;
    logic        rdy;
    logic [3:0]  gnt;
    logic [31:0] y;
    logic [1:0]  sel;
    logic        vld;
  } vec_t;

  vec_t vecs[$];

  mux4x32_rr_arbiter dut (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .Req   (Req),
    .A0    (A0),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .Ready (Ready),
    .Gnt   (Gnt),
    .Y     (Y),
    .Sel   (Sel),
    .Valid (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic [3:0] rq,
    input logic [31:0] x0, input logic [31:0] x1,
    input logic [31:0] x2, input logic [31:0] x3,
    input logic rd, input logic [3:0] g,
    input logic [31:0] yy, input logic [1:0] s, input logic v);
    vec_t t;
    t.name = nm; t.req = rq;
    t.a0 = x0; t.a1 = x1; t.a2 = x2; t.a3 = x3;
    t.rdy = rd; t.gnt = g; t.y = yy; t.sel = s; t.vld = v;
    return t;
  endfunction

  task automatic chk_out(input string nm, input logic [3:0] g,
                         input logic [31:0] yy, input logic [1:0] s,
                         input logic v);
    chk({nm, ".gnt"}, {28'd0, Gnt}, {28'd0, g});
    chk({nm, ".y"}, Y, yy);
    chk({nm, ".sel"}, {30'd0, Sel}, {30'd0, s});
    chk({nm, ".valid"}, {31'd0, Valid}, {31'd0, v});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Clrn  = 1'b0;
    Req   = 4'd0;
    A0 = '0; A1 = '0; A2 = '0; A3 = '0;
    Ready = 1'b0;

    // Full rotation from ptr 0.
    vecs.push_back(mk("rot0", 4'b1111, W0, W1, W2, W3, 1, 4'b0001, W0, 0, 1));
    vecs.push_back(mk("rot1", 4'b1111, W0, W1, W2, W3, 1, 4'b0010, W1, 1, 1));
    vecs.push_back(mk("rot2", 4'b1111, W0, W1, W2, W3, 1, 4'b0100, W2, 2, 1));
    vecs.push_back(mk("rot3", 4'b1111, W0, W1, W2, W3, 1, 4'b1000, W3, 3, 1));
    vecs.push_back(mk("rot4", 4'b1111, W0, W1, W2, W3, 1, 4'b0001, W0, 0, 1));
    // Load W1/sel 1, then backpressure with Req=1101.
    vecs.push_back(mk("bp_ld", 4'b0010, W0, W1, W2, W3, 1, 4'b0010, W1, 1, 1));
    vecs.push_back(mk("bp_h0", 4'b1101, W0, W1, W2, W3, 0, 4'b0000, W1, 1, 1));
    vecs.push_back(mk("bp_h1", 4'b1101, W0, W1, W2, W3, 0, 4'b0000, W1, 1, 1));
    vecs.push_back(mk("bp_h2", 4'b1101, W0, W1, W2, W3, 0, 4'b0000, W1, 1, 1));
    vecs.push_back(mk("bp_go", 4'b1101, W0, W1, W2, W3, 1, 4'b0100, W2, 2, 1));
    // Pointer wrap 3 -> 0.
    vecs.push_back(mk("wr_g3", 4'b1000, W0, W1, W2, W3, 1, 4'b1000, W3, 3, 1));
    vecs.push_back(mk("wr_g0", 4'b1001, WF, W1, W2, WA, 1, 4'b0001, WF, 0, 1));
    vecs.push_back(mk("wr_g3b", 4'b1001, WF, W1, W2, WA, 1, 4'b1000, WA, 3, 1));
    // Single request then drop.
    vecs.push_back(mk("sg_cap", 4'b0001, W0, W1, W2, W3, 1, 4'b0001, W0, 0, 1));
    vecs.push_back(mk("sg_drn", 4'b0000, W0, W1, W2, W3, 1, 4'b0000, W0, 0, 0));
    // Lone requester held: alternate-cycle grants.
    vecs.push_back(mk("lone0", 4'b0100, W0, W1, W2, W3, 1, 4'b0100, W2, 2, 1));
    vecs.push_back(mk("lone1", 4'b0100, W0, W1, W2, W3, 1, 4'b0000, W2, 2, 0));
    vecs.push_back(mk("lone2", 4'b0100, W0, W1, W2, W3, 1, 4'b0100, W2, 2, 1));
    vecs.push_back(mk("lone3", 4'b0100, W0, W1, W2, W3, 1, 4'b0000, W2, 2, 0));
    // Ready is ignored while empty.
    vecs.push_back(mk("emp_r0", 4'b0000, W0, W1, W2, W3, 0, 4'b0000, W2, 2, 0));
    vecs.push_back(mk("emp_cap", 4'b0010, W0, W1, W2, W3, 0, 4'b0010, W1, 1, 1));
    vecs.push_back(mk("full_h", 4'b0000, W0, W1, W2, W3, 0, 4'b0000, W1, 1, 1));
    vecs.push_back(mk("full_d", 4'b0000, W0, W1, W2, W3, 1, 4'b0000, W1, 1, 0));

    // Reset state, then load ABCDEF01.
    repeat (2) @(posedge Clk);
    #1;
    chk_out("rst", 4'b0000, 32'd0, 2'd0, 1'b0);
    Clrn = 1'b1;
    Req  = 4'b0100;
    A2   = W2;
    @(posedge Clk);
    #1;
    chk_out("load", 4'b0100, W2, 2'd2, 1'b1);

    // Asynchronous reset between edges, no clock.
    Req = 4'b0000;
    #2;
    Clrn = 1'b0;
    #1;
    chk_out("arst", 4'b0000, 32'd0, 2'd0, 1'b0);

    Req = 4'b1111;
    A0 = W0; A1 = W1; A2 = W2; A3 = W3;
    Ready = 1'b1;
    #2;
    Clrn = 1'b1;

    foreach (vecs[i]) begin
      Req   = vecs[i].req;
      A0    = vecs[i].a0;
      A1    = vecs[i].a1;
      A2    = vecs[i].a2;
      A3    = vecs[i].a3;
      Ready = vecs[i].rdy;
      @(posedge Clk);
      #1;
      chk_out(vecs[i].name, vecs[i].gnt, vecs[i].y,
              vecs[i].sel, vecs[i].vld);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4x32_rr_arbiter.md
# mux4x32_rr_arbiter

Round-robin arbiter that shares one 32-bit result slot between four requesters. It wraps a MUX4X32 whose select is driven by the arbitration winner, and registers the selected word into an output slot with a valid/ready handshake toward the consumer. It sits in front of the shared write-back/result path, where up to four producers compete for one 32-bit bus.

## Interface
- No parameters. Data width is fixed at 32 and there are exactly 4 requesters.
- Clk  in  1  system clock, rising-edge active
- Clrn  in  1  reset, asynchronous, active-low
- Req  in  4  request per requester; bit i belongs to requester i
- A0, A1, A2, A3  in  32 each  requester data words, fed to the internal MUX4X32
- Ready  in  1  consumer accepts Y in the current cycle
- Gnt  out  4  one-hot grant, registered; one-cycle pulse on the edge where A[i] is captured
- Y  out  32  registered output word
- Sel  out  2  registered index of the requester whose word is in Y
- Valid  out  1  Y holds an unconsumed word

## Operation
- Slot states:
  - EMPTY: Valid=0.
  - FULL: Valid=1.
- Slot free: `free = !Valid || Ready`.
- Eligible requests: `elig = Req & ~Gnt`. A requester whose Gnt is currently high is masked for that cycle.
- Round-robin search: order is Ptr, Ptr+1, Ptr+2, Ptr+3, all mod 4. The first eligible index is the winner w. The combinational winner drives the MUX4X32 select.
- Capture: on a rising edge with free=1 and elig≠0:
  - Y ← A[w], Sel ← w, Valid ← 1
  - Gnt ← onehot(w)
  - Ptr ← (w+1) mod 4
- Drain: on a rising edge with free=1 and elig=0:
  - Valid ← 0, Gnt ← 0
  - Y and Sel hold their last values
  - Ptr unchanged
- Hold: on a rising edge with free=0 (FULL and Ready=0):
  - Y, Sel, Valid, Ptr hold
  - Gnt ← 0
  - Requests wait.
- Transitions:
  - EMPTY→FULL on capture.
  - FULL→FULL on capture with Ready=1 (back-to-back), or on hold.
  - FULL→EMPTY on drain.
- Requester protocol:
  - Keep Req[i] high and A[i] stable until Gnt[i] is seen high.
  - Deassert Req[i] at the following edge unless another word is pending.
  - Holding Req[i] high re-requests.
- Consumer protocol: a word transfers on any edge where Valid=1 and Ready=1. Ready is ignored while Valid=0.
- Gnt is never multi-hot. Gnt=0 whenever no capture occurred on the last edge.

## Timing
- Reset (Clrn=0, immediate, independent of Clk): Gnt=0, Y=0, Sel=0, Valid=0, Ptr=0. A word in flight is dropped. The first arbitration after release starts at requester 0.
- Latency: a Req sampled at edge k with the slot free gives Y/Valid/Sel/Gnt visible after edge k. That is one cycle from request to valid data.
- Throughput:
  - With Ready=1 and at least two distinct requesters pending: one word per cycle.
  - A single requester holding Req high continuously is granted on alternate cycles, because of the Gnt mask.
- Fairness: with all four requesting continuously, any requester waits at most 3 grants between its own grants.
- Simultaneous accept and capture: the old Y is consumed and the new Y is loaded on the same edge, with no bubble.
- Ptr wrap: 3→0.
- Ready changes while Valid=0 have no effect.

## Test plan
- Reset:
  - Load the slot with Y=32'hABCDEF01, then pull Clrn low between edges.
  - Expect Valid=0, Y=0, Sel=0, Gnt=0 immediately, without a clock.
  - After release with Req=4'b1111, expect the first grant to go to requester 0.
- Single request:
  - Stimulus: Req=4'b0001, A0=32'h12345678, Ready=1.
  - After one edge: Valid=1, Y=32'h12345678, Sel=0, Gnt=4'b0001.
  - Drop Req: next edge gives Valid=0, Gnt=0.
- Full rotation:
  - Stimulus: A0..A3 = 32'h12345678, 32'h87654321, 32'hABCDEF01, 32'h10101010; Req=4'b1111 held; Ready=1.
  - Expect Sel sequence 0,1,2,3,0 on consecutive cycles, with Y matching each word and Gnt a one-hot pulse each cycle.
- Backpressure:
  - While Valid=1 with Y=32'h87654321 and Sel=1, hold Ready=0 for 3 cycles with Req=4'b1101.
  - Expect Y, Sel and Valid to hold and Gnt=0 throughout.
  - Raise Ready: the next edge captures requester 2 (Y=32'hABCDEF01).
- Pointer wrap:
  - After a grant to 3, apply Req=4'b1001 with A0=32'hFFFFFFFF and A3=32'hAAAAAAAA.
  - Expect grant 0 (Y=32'hFFFFFFFF), then grant 3 (Y=32'hAAAAAAAA).
- Lone requester: Req=4'b0100 held with Ready=1 gives Gnt[2] pulses and Valid=1 on alternate cycles only.
